// File: rtl/periph_pkg.sv
// ---------------------------------------------------------------------------
// periph_pkg
//   Shared constants for the memory-mapped peripheral block:
//   - byte offsets of each register inside the 0x4000_00xx window
//     (only Address[4:2] is decoded, so offsets are compared as
//     {Address[4:2], 2'b00})
//   - bit positions inside TCON
//   - seven-segment codes for hex digits 0..F, bit order {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package periph_pkg;

  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_SWITCH  = 5'h10;
  localparam logic [4:0] OFF_DIGI    = 5'h14;
  localparam logic [4:0] OFF_SYSTICK = 5'h18;

  localparam int TCON_RUN = 0;  // timer counts while set
  localparam int TCON_IE  = 1;  // interrupt enable
  localparam int TCON_IS  = 2;  // interrupt status (sticky until software clears)

  // Packed array: element [n] is the segment pattern for hex value n.
  localparam logic [15:0][7:0] SEG_CODE = {
    8'h71, 8'h79, 8'h5E, 8'h39,   // F E d C
    8'h7C, 8'h77, 8'h6F, 8'h7F,   // b A 9 8
    8'h07, 8'h7D, 8'h6D, 8'h66,   // 7 6 5 4
    8'h4F, 8'h5B, 8'h06, 8'h3F    // 3 2 1 0
  };

endpackage

// File: rtl/peripheral_bus_if.sv
// ---------------------------------------------------------------------------
// peripheral_bus_if
//   CPU load/store bus as seen by the peripheral block. Signal names follow
//   the CPU datapath so the same bundle can sit beside data memory.
//     Address    [31:0]  byte address
//     Write_data [31:0]  store data
//     MemRead            read enable
//     MemWrite           write enable
//     Read_data  [31:0]  combinational read data (slave drives)
//   Modports: master = CPU side, slave = peripheral side.
// ---------------------------------------------------------------------------
interface peripheral_bus_if;

  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;

  modport master (
    output Address, Write_data, MemRead, MemWrite,
    input  Read_data
  );

  modport slave (
    input  Address, Write_data, MemRead, MemWrite,
    output Read_data
  );

endinterface

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
//   Multiplexed four-digit hex display driver. A divide counter holds each
//   digit lit for SCAN_DIV cycles; the digit index then advances 0->1->2->3.
//   The segment pattern is decoded combinationally from the live DIGI value,
//   so a new value shows immediately without disturbing the scan position.
//   Ports:
//     clk          system clock
//     reset        asynchronous, active-low
//     i_digi[15:0] four hex nibbles, nibble 0 = rightmost digit
//     o_digi[11:0] {anodes[3:0] active-low one-hot-zero, {dp,g..a}}
//   Parameter: SCAN_DIV (>= 2) cycles per digit.
// ---------------------------------------------------------------------------
module seg7_scan
  import periph_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_digi,
  output logic [11:0] o_digi
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic             w_tc;
  logic [3:0]       w_nibble;
  logic [3:0]       w_anode;

  assign w_tc = (r_div == DIV_W'(SCAN_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_tc) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign w_nibble = i_digi[{r_idx, 2'b00} +: 4];
  assign w_anode  = ~(4'b0001 << r_idx);
  assign o_digi   = {w_anode, SEG_CODE[w_nibble]};

endmodule

// File: rtl/peripheral_bus.sv
// ---------------------------------------------------------------------------
// peripheral_bus
//   Memory-mapped peripherals for the single-cycle MIPS CPU, selected when
//   Address[31:8] == BASE_ADDR. Registers (Address[4:2] decodes):
//     0x00 TH (reload)  0x04 TL (counter)  0x08 TCON {IS,IE,RUN}
//     0x0C LED          0x10 SWITCH (RO)   0x14 DIGI  0x18 SYSTICK (RO)
//   Reads are combinational and return 0 when deselected, unmapped or
//   MemRead is low, so the datapath can mux this with data memory.
//   Ports:
//     clk, reset (async, active-low)
//     cpu     peripheral_bus_if.slave CPU load/store bus
//     switch  board switches (sampled directly)
//     led     LED register
//     digi    {anodes, segments} from the display scanner
//     irq     timer interrupt, level = TCON.IE & TCON.IS
//   Build option: define PERIPH_SYSTICK_EN to include the free-running
//   SYSTICK cycle counter; otherwise offset 0x18 reads 0.
// ---------------------------------------------------------------------------
module peripheral_bus
  import periph_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h400000,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  peripheral_bus_if.slave        cpu,
  input  logic [7:0]             switch,
  output logic [7:0]             led,
  output logic [11:0]            digi,
  output logic                   irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic [7:0]  r_led;
  logic [15:0] r_digi;

  logic        w_sel;
  logic [4:0]  w_off;
  logic        w_wr;
  logic [31:0] w_systick;
  logic [31:0] w_read_data;
  logic        w_unused_addr;

  assign w_sel = (cpu.Address[31:8] == BASE_ADDR);
  assign w_off = {cpu.Address[4:2], 2'b00};
  assign w_wr  = cpu.MemWrite & w_sel;

  // Address bits outside the register decode are deliberately ignored,
  // so registers alias across the upper part of the 256-byte window.
  assign w_unused_addr = ^{cpu.Address[7:5], cpu.Address[1:0]};

  // Plain CPU-owned registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th   <= '0;
      r_led  <= '0;
      r_digi <= '0;
    end else if (w_wr) begin
      case (w_off)
        OFF_TH:   r_th   <= cpu.Write_data;
        OFF_LED:  r_led  <= cpu.Write_data[7:0];
        OFF_DIGI: r_digi <= cpu.Write_data[15:0];
        default:  ;
      endcase
    end
  end

  // Timer. The CPU write is placed after the timer update so that, when
  // both touch TL or TCON on the same edge, the later assignment (the
  // store) is the one that lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (r_tcon[TCON_RUN]) begin
        if (&r_tl) begin
          r_tl <= r_th;
          if (r_tcon[TCON_IE]) r_tcon[TCON_IS] <= 1'b1;
        end else begin
          r_tl <= r_tl + 32'd1;
        end
      end
      if (w_wr && (w_off == OFF_TL))   r_tl   <= cpu.Write_data;
      if (w_wr && (w_off == OFF_TCON)) r_tcon <= cpu.Write_data[2:0];
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] r_systick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_systick <= '0;
    else        r_systick <= r_systick + 32'd1;
  end

  assign w_systick = r_systick;
`else
  assign w_systick = '0;
`endif

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_read_data = '0;
    if (cpu.MemRead && w_sel) begin
      case (w_off)
        OFF_TH:      w_read_data = r_th;
        OFF_TL:      w_read_data = r_tl;
        OFF_TCON:    w_read_data = {29'd0, r_tcon};
        OFF_LED:     w_read_data = {24'd0, r_led};
        OFF_SWITCH:  w_read_data = {24'd0, switch};
        OFF_DIGI:    w_read_data = {16'd0, r_digi};
        OFF_SYSTICK: w_read_data = w_systick;
        default:     w_read_data = '0;
      endcase
    end
  end

  assign cpu.Read_data = w_read_data;
  assign led           = r_led;
  assign irq           = r_tcon[TCON_IE] & r_tcon[TCON_IS];

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg7_scan (
    .clk    (clk),
    .reset  (reset),
    .i_digi (r_digi),
    .o_digi (digi)
  );

endmodule

// File: tb/tb_peripheral_bus.sv
// ---------------------------------------------------------------------------
// tb_peripheral_bus
//   Self-checking bench for peripheral_bus. A behavioural model (register
//   variables updated once per clock edge, display position derived from
//   the number of edges since reset) predicts every read and output.
//   Directed cases cover reset, LED/DIGI, timer wrap with and without
//   interrupt, write-over-timer priority, zero reads, the switch port and
//   SYSTICK; a randomized phase then exercises the bus against the model.
// ---------------------------------------------------------------------------
module tb_peripheral_bus;

  localparam int SCAN_DIV = 4;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_TICK = 32'h4000_0018;
  localparam logic [31:0] A_NONE = 32'h4000_001C;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  peripheral_bus_if cpu ();

  peripheral_bus #(
    .BASE_ADDR (24'h400000),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .cpu    (cpu.slave),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [15:0] m_digi;
  int          m_edges;

  task automatic model_clear();
    m_th = '0; m_tl = '0; m_tcon = '0; m_led = '0; m_digi = '0;
    m_systick = '0; m_edges = 0;
  endtask

  task automatic model_edge();
    logic [31:0] tl;
    logic [2:0]  tc;
    logic [31:0] wd;
    if (!reset) begin
      model_clear();
      return;
    end
    tl = m_tl;
    tc = m_tcon;
    wd = cpu.Write_data;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        tl = m_th;
        if (m_tcon[1]) tc[2] = 1'b1;
      end else begin
        tl = m_tl + 32'd1;
      end
    end
    if (cpu.MemWrite && cpu.Address[31:8] == 24'h400000) begin
      case (cpu.Address[4:2])
        3'd0: m_th   = wd;
        3'd1: tl     = wd;
        3'd2: tc     = wd[2:0];
        3'd3: m_led  = wd[7:0];
        3'd5: m_digi = wd[15:0];
        default: ;
      endcase
    end
    m_tl = tl;
    m_tcon = tc;
    m_systick = m_systick + 32'd1;
    m_edges++;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic rd);
    if (!rd || addr[31:8] != 24'h400000) return 32'd0;
    case (addr[4:2])
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'd0, m_tcon};
      3'd3: return {24'd0, m_led};
      3'd4: return {24'd0, switch};
      3'd5: return {16'd0, m_digi};
`ifdef PERIPH_SYSTICK_EN
      3'd6: return m_systick;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [11:0] exp_digi();
    int         idx;
    logic [3:0] an;
    logic [3:0] nib;
    idx = (m_edges / SCAN_DIV) % 4;
    an  = 4'b0001 << idx;
    nib = m_digi[idx*4 +: 4];
    return {~an, seg_tab[nib]};
  endfunction

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wd);
    cpu.MemWrite   = we;
    cpu.MemRead    = re;
    cpu.Address    = addr;
    cpu.Write_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd);
    drive(1'b1, 1'b0, addr, wd);
    tick();
    idle();
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, 1'b1, addr, 32'd0);
    #1;
    check(tag, cpu.Read_data, exp);
    idle();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_led"},  {24'd0, led},  {24'd0, m_led});
    check({tag, "_irq"},  {31'd0, irq},  {31'd0, m_tcon[1] & m_tcon[2]});
    check({tag, "_digi"}, {20'd0, digi}, {20'd0, exp_digi()});
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] s0, s1, addr, wd;
  logic        we, re;
  logic [2:0]  off;

  initial begin
    reset  = 1'b0;
    switch = 8'h00;
    idle();
    model_clear();
    #2;

    // Reset state: every register reads zero, outputs at reset values.
    for (int i = 0; i < 8; i++) read_chk("rst_read", A_TH + 32'(i * 4), 32'd0);
    check("rst_digi", {20'd0, digi}, 32'hE3F);
    check("rst_led",  {24'd0, led},  32'd0);
    check("rst_irq",  {31'd0, irq},  32'd0);
    bus_write(A_LED, 32'hFF);
    read_chk("rst_wr_ignored", A_LED, 32'd0);
    check("rst_wr_led", {24'd0, led}, 32'd0);
    reset = 1'b1;

    // LED / DIGI and the display scan.
    bus_write(A_LED, 32'hA5);
    bus_write(A_DIGI, 32'h1234);
    read_chk("led_rd", A_LED, 32'hA5);
    read_chk("digi_rd", A_DIGI, 32'h1234);
    check("led_pin", {24'd0, led}, 32'hA5);
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      check_outputs("scan");
      tick();
    end

    // Timer wrap with interrupt enabled.
    bus_write(A_TH, 32'hFFFF_FFFC);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd3);
    tick();
    tick();
    read_chk("wrap_tl", A_TL, 32'hFFFF_FFFC);
    check("wrap_irq", {31'd0, irq}, 32'd1);
    read_chk("wrap_tcon", A_TCON, 32'd7);
    bus_write(A_TCON, 32'd3);
    check("irq_clr", {31'd0, irq}, 32'd0);
    read_chk("tl_running", A_TL, 32'hFFFF_FFFD);

    // Wrap with interrupt disabled.
    bus_write(A_TCON, 32'd0);
    bus_write(A_TH, 32'h77);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd1);
    tick();
    tick();
    read_chk("noie_tl", A_TL, 32'h77);
    read_chk("noie_tcon", A_TCON, 32'd1);
    check("noie_irq", {31'd0, irq}, 32'd0);

    // CPU write to TL wins over the timer increment.
    bus_write(A_TCON, 32'd0);
    bus_write(A_TL, 32'd5);
    bus_write(A_TCON, 32'd1);
    read_chk("tl_before", A_TL, 32'd5);
    bus_write(A_TL, 32'h10);
    read_chk("tl_override", A_TL, 32'h10);
    tick();
    read_chk("tl_after", A_TL, 32'h11);
    bus_write(A_TCON, 32'd0);

    // Zero reads.
    read_chk("unmapped", A_NONE, 32'd0);
    read_chk("deselect", 32'h1000_0000, 32'd0);
    drive(1'b0, 1'b0, A_TICK, 32'd0);
    #1;
    check("no_memread", cpu.Read_data, 32'd0);
    idle();

    // Switch port is read-only.
    switch = 8'h3C;
    read_chk("switch", A_SW, 32'h3C);
    bus_write(A_SW, 32'hFF);
    read_chk("switch_ro", A_SW, 32'h3C);
    read_chk("led_kept", A_LED, 32'hA5);

    // SYSTICK.
    drive(1'b0, 1'b1, A_TICK, 32'd0);
    #1;
    s0 = cpu.Read_data;
    idle();
    for (int i = 0; i < 5; i++) tick();
    drive(1'b0, 1'b1, A_TICK, 32'd0);
    #1;
    s1 = cpu.Read_data;
    idle();
`ifdef PERIPH_SYSTICK_EN
    check("systick_diff", s1 - s0, 32'd5);
`else
    check("systick_diff", s1 - s0, 32'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      off  = 3'($urandom_range(0, 7));
      we   = 1'($urandom_range(0, 1));
      re   = 1'($urandom_range(0, 1));
      addr = (($urandom_range(0, 7) == 0) ? 32'h1000_0000 : 32'h4000_0000)
             | (32'($urandom_range(0, 7)) << 5) | (32'(off) << 2);
      case (off)
        3'd1:    wd = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
        3'd2:    wd = 32'($urandom_range(0, 7));
        default: wd = $urandom;
      endcase
      switch = 8'($urandom);
      drive(we, re, addr, wd);
      #1;
      check("rand_rd", cpu.Read_data, model_read(addr, re));
      check_outputs("rand");
      tick();
    end
    idle();

    // Reset in the middle of a scan, then a full restart from digit 0.
    reset = 1'b0;
    model_clear();
    #1;
    check("midrst_digi", {20'd0, digi}, 32'hE3F);
    read_chk("midrst_tl", A_TL, 32'd0);
    check("midrst_led", {24'd0, led}, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4 * SCAN_DIV + 2; i++) begin
      if (i == 0) drive(1'b1, 1'b0, A_DIGI, 32'h1234);
      else        idle();
      #1;
      check_outputs("restart");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
